i2c_slave_regfile: RTL

Synthesizable, parametrised I2C slave register file running on the system clock. SCL/SDA are oversampled, synchronised and glitch-filtered. It exposes NUM_REGS byte registers to an I2C master, with pointer auto-increment, repeated-start support and range-checked ACK/NACK. A host-side port lets odometry logic publish values and observe master writes.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_pin_filter.sv | 47 ++++
 rtl/i2c_slave_regfile.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register file.
//   state_t      : FSM state encoding (legacy-compatible localparam constants)
//   I2C_ACK/NACK : SDA level of an acknowledge bit
//   RW_WRITE/READ: value of the R/W bit that follows the 7-bit address
package i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_ADDR      = 4'd1;
  localparam state_t ST_ADDR_ACK  = 4'd2;
  localparam state_t ST_PTR       = 4'd3;
  localparam state_t ST_PTR_ACK   = 4'd4;
  localparam state_t ST_WDATA     = 4'd5;
  localparam state_t ST_WDATA_ACK = 4'd6;
  localparam state_t ST_RDATA     = 4'd7;
  localparam state_t ST_RDATA_ACK = 4'd8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_pin_filter.sv
// Synchroniser, glitch filter and edge detector for one I2C pin.
//   clk, rst : system clock, synchronous active-high reset
//   pin      : raw asynchronous pin level
//   level    : filtered level (changes only after FILT_LEN equal samples)
//   rise     : one-cycle pulse when level goes 0 -> 1
//   fall     : one-cycle pulse when level goes 1 -> 0
// Everything presets to 1 (bus idle level) so no edge follows reset.
// FILT_LEN must be at least 2.
module i2c_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [FILT_LEN-1:0]    hist_p1;
  logic                   level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      hist_p1 <= '1;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      // stage p0: metastability synchroniser
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
      // stage p1: sample history; level moves only when all samples agree
      hist_p1 <= {hist_p1[FILT_LEN-2:0], sync_p0[SYNC_STAGES-1]};
      if (&hist_p1)
        level <= 1'b1;
      else if (~|hist_p1)
        level <= 1'b0;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing NUM_REGS byte registers, with pointer auto-increment,
// repeated-start support and range-checked ACK/NACK.
//   clk, rst          : system clock (>= 20x SCL), synchronous active-high reset
//   scl_i, sda_i      : raw bus pin levels
//   sda_oe            : 1 pulls SDA low (open drain)
//   host_wr_*         : host register write port (host wins on collisions)
//   host_rd_addr/data : combinational host read port
//   i2c_wr_*          : one-cycle report of each accepted master data byte
//   busy              : high from address match until STOP or NACK exit
module i2c_slave_regfile import i2c_pkg::*; #(
  parameter logic [6:0] I2C_ADR     = 7'h11,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [7:0]    host_wr_data,
  input  logic [AW-1:0] host_rd_addr,
  output logic [7:0]    host_rd_data,
  output logic          i2c_wr_valid,
  output logic [AW-1:0] i2c_wr_addr,
  output logic [7:0]    i2c_wr_data,
  output logic          busy
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin(scl_i), .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin(sda_i), .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_evt, stop_evt;
  assign start_evt = scl_f & sda_fall;
  assign stop_evt  = scl_f & sda_rise;

  logic [7:0] regs [NUM_REGS];
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sr, tx, ptr;
  logic       rw;
  logic       pend;   // ACK bit or next read MSB waiting for the coming scl_fall

  logic [7:0] sr_next, tx_load;
  logic       ptr_ok, sr_ok;

  assign sr_next = {sr[6:0], sda_f};
  assign ptr_ok  = {1'b0, ptr} < NUM_REGS_W;
  assign sr_ok   = {1'b0, sr_next} < NUM_REGS_W;
  // Out-of-range reads return all ones, as an idle bus would.
  assign tx_load = ptr_ok ? regs[ptr[AW-1:0]] : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd7;
      ptr          <= '0;
      rw           <= RW_WRITE;
      pend         <= 1'b0;
      busy         <= 1'b0;
      sda_oe       <= 1'b0;
      i2c_wr_valid <= 1'b0;
    end else begin
      i2c_wr_valid <= 1'b0;
      if (stop_evt) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        pend   <= 1'b0;
      end else if (start_evt) begin
        // ptr survives so a pointer write can be followed by Sr + read
        state   <= ST_ADDR;
        bit_cnt <= 3'd7;
        pend    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            sr <= sr_next;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
            end else if (sr_next[7:1] == I2C_ADR) begin
              rw    <= sr_next[0];
              busy  <= 1'b1;
              pend  <= 1'b1;
              state <= ST_ADDR_ACK;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_PTR: if (scl_rise) begin
            sr <= sr_next;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
            end else begin
              ptr <= sr_next;
              if (sr_ok) begin
                pend  <= 1'b1;
                state <= ST_PTR_ACK;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ST_WDATA: if (scl_rise) begin
            sr <= sr_next;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
            end else if (ptr_ok) begin
              i2c_wr_valid <= 1'b1;
              i2c_wr_addr  <= ptr[AW-1:0];
              i2c_wr_data  <= sr_next;
              ptr          <= ptr + 8'd1;
              pend         <= 1'b1;
              state        <= ST_WDATA_ACK;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          // First scl_fall drives the ACK, second one ends the ACK bit.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
            if (pend) begin
              sda_oe <= ~I2C_ACK;
              pend   <= 1'b0;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              if (state == ST_ADDR_ACK && rw == RW_READ) begin
                tx     <= tx_load;
                sda_oe <= ~tx_load[7];
                state  <= ST_RDATA;
              end else if (state == ST_ADDR_ACK) begin
                state <= ST_PTR;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          // tx is a snapshot, so host writes cannot tear the byte in flight.
          ST_RDATA: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0;
              ptr    <= ptr + 8'd1;
              state  <= ST_RDATA_ACK;
            end else begin
              tx      <= {tx[6:0], 1'b0};
              sda_oe  <= ~tx[6];
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_f == I2C_NACK) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                tx   <= tx_load;
                pend <= 1'b1;
              end
            end else if (scl_fall && pend) begin
              sda_oe  <= ~tx[7];
              bit_cnt <= 3'd7;
              pend    <= 1'b0;
              state   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Host write is applied last so it overrides a same-cycle I2C write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= 8'h00;
    end else begin
      if (i2c_wr_valid)
        regs[i2c_wr_addr] <= i2c_wr_data;
      if (host_wr_en)
        regs[host_wr_addr] <= host_wr_data;
    end
  end

  assign host_rd_data = regs[host_rd_addr];

endmodule
